// File: rtl/audio_in_pkg.sv
// Shared types and constants for the TDM audio input deserializer.
package audio_in_pkg;

  // Capture state machine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } deser_state_e;

  // Frame-sync to slot-0 MSB distance for the two supported framings.
  localparam int I2S_DELAY = 1;
  localparam int LJ_DELAY  = 0;

  // Per-channel space field is {full, words_used}: one bit wider than the address.
  function automatic int space_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is held in a registered
// output stage; a word written into an (effectively) empty FIFO is
// forwarded straight into that stage so it is visible right after the write.
module audio_sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] words_used
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [DATA_WIDTH-1:0] head_reg;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  bypass;
  logic                  goes_empty;

  // Accept logic: pops need data, pushes need room unless a pop frees a slot.
  always_comb begin
    pop_ok      = pop && (count_reg != '0);
    push_ok     = push && (!count_reg[ADDR_WIDTH] || pop_ok);
    rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(pop_ok);
    goes_empty  = (count_reg == (ADDR_WIDTH + 1)'(pop_ok));
    bypass      = push_ok && goes_empty;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + (ADDR_WIDTH + 1)'(push_ok) - (ADDR_WIDTH + 1)'(pop_ok);
    end
  end

  // Registered head word: forwarded write, zero when draining, else next entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
    end else if (bypass) begin
      head_reg <= push_data;
    end else if (goes_empty) begin
      head_reg <= '0;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  assign pop_data   = head_reg;
  assign empty      = (count_reg == '0);
  assign full       = count_reg[ADDR_WIDTH];
  assign words_used = count_reg[ADDR_WIDTH-1:0];

endmodule

// File: rtl/audio_in_tdm_deserializer.sv
// TDM / I2S audio input deserializer with one show-ahead FIFO per slot.
// Optional feature macro AUDIO_IN_DESER_SIGN_EXTEND_EN: adds OUT_BITS and
// sign-extends each channel's read_data from the sample MSB.
module audio_in_tdm_deserializer
  import audio_in_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_BITS = 24,
  parameter int SLOT_BITS   = 32,
  parameter int FRAME_DELAY = I2S_DELAY,
  parameter int ADDR_WIDTH  = 7
`ifdef AUDIO_IN_DESER_SIGN_EXTEND_EN
  ,
  parameter int OUT_BITS    = 32
`endif
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       bit_clk_rising_edge,
  input  logic                                       frame_sync_edge,
  input  logic                                       done_channel_sync,
  input  logic                                       serial_audio_in_data,
  input  logic [NUM_CH-1:0]                          read_en,
  input  logic [NUM_CH-1:0]                          clear_overflow,
`ifdef AUDIO_IN_DESER_SIGN_EXTEND_EN
  output logic [NUM_CH*OUT_BITS-1:0]                 read_data,
`else
  output logic [NUM_CH*SAMPLE_BITS-1:0]              read_data,
`endif
  output logic [NUM_CH*space_width(ADDR_WIDTH)-1:0]  fifo_read_space,
  output logic [NUM_CH-1:0]                          fifo_empty,
  output logic [NUM_CH-1:0]                          overflow
);

`ifdef AUDIO_IN_DESER_SIGN_EXTEND_EN
  localparam int CH_BITS = OUT_BITS;
`else
  localparam int CH_BITS = SAMPLE_BITS;
`endif
  localparam int SPACE_W = space_width(ADDR_WIDTH);
  localparam int SLOT_W  = $clog2(NUM_CH);
  localparam int BIT_W   = $clog2(SLOT_BITS + 1);
  localparam bit HAS_PAD = (SLOT_BITS > SAMPLE_BITS);

  localparam logic [BIT_W-1:0]  LAST_SAMPLE_BIT = BIT_W'(SAMPLE_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_SLOT_BIT   = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_DELAY_BIT  = BIT_W'((FRAME_DELAY > 0) ? FRAME_DELAY - 1 : 0);
  localparam logic [SLOT_W-1:0] LAST_SLOT       = SLOT_W'(NUM_CH - 1);

  deser_state_e            state_reg;
  logic [SLOT_W-1:0]       slot_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [SAMPLE_BITS-1:0]  shift_reg;
  logic [SAMPLE_BITS-1:0]  shifted;
  logic                    push_reg;
  logic [SLOT_W-1:0]       push_slot_reg;
  logic [SAMPLE_BITS-1:0]  push_data_reg;

  assign shifted = {shift_reg[SAMPLE_BITS-2:0], serial_audio_in_data};

  // Capture state machine: frame delay, MSB-first sample bits, then slot padding.
  always_ff @(posedge clk) begin
    push_reg <= 1'b0;
    if (reset) begin
      state_reg     <= IDLE;
      slot_reg      <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      push_slot_reg <= '0;
      push_data_reg <= '0;
    end else if (!done_channel_sync) begin
      // Link down: abandon any partially shifted sample.
      state_reg   <= IDLE;
      slot_reg    <= '0;
      bit_cnt_reg <= '0;
    end else if (frame_sync_edge) begin
      // A frame sync always restarts at slot 0, even mid-frame.
      slot_reg    <= '0;
      bit_cnt_reg <= '0;
      state_reg   <= (FRAME_DELAY == 0) ? SHIFT : DELAY;
    end else if (bit_clk_rising_edge) begin
      case (state_reg)
        DELAY: begin
          if (bit_cnt_reg == LAST_DELAY_BIT) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          shift_reg <= shifted;
          if (bit_cnt_reg == LAST_SAMPLE_BIT) begin
            push_reg      <= 1'b1;
            push_slot_reg <= slot_reg;
            push_data_reg <= shifted;
            if (HAS_PAD) begin
              state_reg   <= PAD;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else begin
              bit_cnt_reg <= '0;
              if (slot_reg == LAST_SLOT) begin
                state_reg <= IDLE;
                slot_reg  <= '0;
              end else begin
                state_reg <= SHIFT;
                slot_reg  <= slot_reg + 1'b1;
              end
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        PAD: begin
          if (bit_cnt_reg == LAST_SLOT_BIT) begin
            bit_cnt_reg <= '0;
            if (slot_reg == LAST_SLOT) begin
              state_reg <= IDLE;
              slot_reg  <= '0;
            end else begin
              state_reg <= SHIFT;
              slot_reg  <= slot_reg + 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                   ch_push;
      logic                   ch_drop;
      logic [SAMPLE_BITS-1:0] head;
      logic                   ch_full;
      logic [ADDR_WIDTH-1:0]  ch_used;
      logic [SPACE_W-1:0]     space_reg;
      logic                   overflow_reg;

      // A push registered just before the link dropped is still discarded.
      assign ch_push = push_reg && done_channel_sync && (push_slot_reg == SLOT_W'(gi));
      // Full means non-empty, so a same-cycle read always frees a slot.
      assign ch_drop = ch_push && ch_full && !read_en[gi];

      audio_sync_fifo #(
        .DATA_WIDTH (SAMPLE_BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (ch_push),
        .push_data  (push_data_reg),
        .pop        (read_en[gi]),
        .pop_data   (head),
        .empty      (fifo_empty[gi]),
        .full       (ch_full),
        .words_used (ch_used)
      );

      // Registered occupancy report, one cycle behind the FIFO.
      always_ff @(posedge clk) begin
        if (reset) begin
          space_reg <= '0;
        end else begin
          space_reg <= {ch_full, ch_used};
        end
      end

      // Sticky overflow; a drop in the same cycle outranks a clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          overflow_reg <= 1'b0;
        end else if (ch_drop) begin
          overflow_reg <= 1'b1;
        end else if (clear_overflow[gi]) begin
          overflow_reg <= 1'b0;
        end
      end

      assign fifo_read_space[gi*SPACE_W +: SPACE_W] = space_reg;
      assign overflow[gi]                           = overflow_reg;
`ifdef AUDIO_IN_DESER_SIGN_EXTEND_EN
      assign read_data[gi*CH_BITS +: CH_BITS] = CH_BITS'($signed(head));
`else
      assign read_data[gi*CH_BITS +: CH_BITS] = head;
`endif
    end
  endgenerate

endmodule

// File: doc/audio_in_tdm_deserializer.md
Name: audio_in_tdm_deserializer

Overview:
- Parametrised successor to the DE2 two-channel ADC deserializer.
- Captures NUM_CH time-division-multiplexed audio slots from the codec serial input. Supports I2S (1-bit delay) or left-justified framing.
- Buffers each channel in its own synchronous FIFO, with sticky per-channel overflow flags.
- Sits between the codec clock-edge generator and the audio register interface; all logic runs on the system clock and uses edge strobes.

Parameters:
- NUM_CH, 2, channel slots per frame (2..16).
- SAMPLE_BITS, 24, captured bits per slot, MSB first (8..32).
- SLOT_BITS, 32, bit clocks per slot (>= SAMPLE_BITS).
- FRAME_DELAY, 1, bit clocks between frame-sync edge and slot-0 MSB (1 = I2S, 0 = left-justified).
- ADDR_WIDTH, 7, FIFO address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bit_clk_rising_edge  in  1  one-cycle strobe: sample serial_audio_in_data.
- frame_sync_edge  in  1  one-cycle strobe: start of frame (slot 0).
- done_channel_sync  in  1  codec link up; when low, no capture and no FIFO writes.
- serial_audio_in_data  in  1  ADC serial data.
- read_en  in  NUM_CH  per-channel pop request.
- clear_overflow  in  NUM_CH  per-channel sticky-flag clear.
- read_data  out  NUM_CH*SAMPLE_BITS  head word per channel; channel c occupies [c*SAMPLE_BITS +: SAMPLE_BITS].
- fifo_read_space  out  NUM_CH*(ADDR_WIDTH+1)  per channel {full, words_used}, registered.
- fifo_empty  out  NUM_CH  per-channel empty.
- overflow  out  NUM_CH  sticky: a sample was dropped on a full FIFO.

Behaviour:
- Reset clears all outputs, FIFOs, counters and flags to 0, except fifo_empty, which resets to all-1. The FSM resets to IDLE.
- FSM states:
  - IDLE: waits for frame_sync_edge while done_channel_sync=1. Then goes to DELAY, or to SHIFT if FRAME_DELAY=0.
  - DELAY: counts FRAME_DELAY bit_clk_rising_edge strobes, then goes to SHIFT.
  - SHIFT: each strobe shifts the input bit into the shift register LSB (MSB-first). After the SAMPLE_BITS-th bit, issues a push to the FIFO of the current slot, then goes to PAD, or directly to the next slot's SHIFT if SLOT_BITS=SAMPLE_BITS.
  - PAD: counts the remaining SLOT_BITS-SAMPLE_BITS strobes. Then either increments the slot and goes to SHIFT, or, after slot NUM_CH-1, goes to IDLE.
- Slot counter width is $clog2(NUM_CH); bit counter width is $clog2(SLOT_BITS+1).
- frame_sync_edge in any non-IDLE state restarts at slot 0 / DELAY; a partially shifted sample is discarded, with no push.
- done_channel_sync falling to 0 forces IDLE the next cycle; an in-flight sample is discarded.
- Push timing: the FIFO write occurs the cycle after the last bit strobe, so read_data and fifo_empty reflect it 2 cycles after that strobe.
- Full handling:
  - Push on a full FIFO with no pop in the same cycle: sample dropped, overflow[c] set, FIFO contents untouched.
  - Push and pop in the same cycle on a full FIFO: both accepted, occupancy unchanged, no overflow.
- Pop: read_en[c] with fifo_empty[c]=0 advances the head; read_data is show-ahead (valid whenever not empty).
  - read_en on an empty FIFO is ignored.
  - Push and pop on an empty FIFO in the same cycle: push only.
- fifo_read_space lags the FIFO state by 1 cycle. words_used wraps to 0 at full, with the full bit set (count = full*2**ADDR_WIDTH + used).
- clear_overflow[c] clears the flag. A simultaneous drop on the same channel takes priority and leaves the flag set.

Optional Feature:
- Macro: AUDIO_IN_DESER_SIGN_EXTEND_EN.
- Defined: adds parameter OUT_BITS (default 32, >= SAMPLE_BITS). read_data per channel is OUT_BITS wide, sign-extended from the sample MSB.
- Undefined: per-channel width is SAMPLE_BITS, with no extension logic.

Decomposition:
- Package audio_in_pkg holds:
  - FSM state enum (IDLE, DELAY, SHIFT, PAD);
  - localparams I2S_DELAY=1 and LJ_DELAY=0;
  - a function computing the per-channel space-field width.
- One sub-module, audio_sync_fifo: parametrised DATA_WIDTH/ADDR_WIDTH, show-ahead, with empty/full/words_used outputs. It is instantiated NUM_CH times in a generate loop.

Test Plan:
- I2S, NUM_CH=2, 24-bit samples:
  - stimulus: slot 0 = 0xA5A5A5, slot 1 = 0x123456;
  - required: read_data ch0 = 0xA5A5A5, ch1 = 0x123456; fifo_read_space = 1 per channel.
- TDM, NUM_CH=8, SLOT_BITS=32, FRAME_DELAY=0:
  - stimulus: slot c carries 0x0000C0+c;
  - required: each FIFO holds its own value; no cross-channel leakage.
- Overflow, ADDR_WIDTH=2:
  - stimulus: 5 frames with no reads;
  - required: full=1, overflow=1 on both channels, first 4 samples intact. clear_overflow then clears the flag.
- Early frame_sync_edge mid-slot 1, after 10 bits:
  - required: no push to ch1; next frame captured correctly from slot 0.
- Reset asserted mid-SHIFT, and done_channel_sync dropped mid-frame:
  - required: FIFOs empty, flags 0, no partial sample pushed; capture resumes on the next sync.
- Simultaneous pop and push on a full FIFO:
  - required: occupancy unchanged, overflow stays 0, FIFO order preserved.
